// File: rtl/execute_if.sv
// execute_if: shared pipeline types and the execute-stage port bundle
package common;
    typedef logic [63:0] word_t;
    typedef logic bool;
    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW, OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        word_t       inst_pc;
        op_t         op;
        word_t       src1;
        word_t       src2;
        word_t       imm;
    } id_ex;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        word_t       inst_pc;
        op_t         op;
        word_t       alu_result;
        word_t       write_mem_data;
    } ex_mem;
endpackage

interface execute_if;
    import common::*;
    id_ex  id_ex_state;
    logic  hold;
    logic  flush;
    ex_mem ex_mem_state;
    bool   ok;
    modport master (output id_ex_state, hold, flush, input ex_mem_state, ok);
    modport slave (input id_ex_state, hold, flush, output ex_mem_state, ok);
endinterface

// File: rtl/execute.sv
// execute: RV64 execute stage, single-cycle ALU plus iterative multiply/divide
module execute
    import common::*;
(
    input  logic     clk,
    input  logic     rst,
    execute_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic word_t sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    id_ex in;
    assign in = bus.id_ex_state;

    state_t       state_q;
    op_t          op_q;
    logic [6:0]   cnt_q;
    logic [127:0] acc_q;
    word_t        opb_q, spec_q;
    logic         special_q, negq_q, negr_q;

    logic        use_imm;
    word_t       b, add, sub, alu_res;
    logic [31:0] sll32, srl32, sra32;

    // Single-cycle integer ALU; immediate forms take imm as the second operand
    always_comb begin
        use_imm = in.op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI,
                                OP_SLTI, OP_SLTIU, OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
                                OP_LOAD, OP_STORE};
        b = use_imm ? in.imm : in.src2;
        add = in.src1 + b;
        sub = in.src1 - b;
        sll32 = in.src1[31:0] << b[4:0];
        srl32 = in.src1[31:0] >> b[4:0];
        sra32 = $signed(in.src1[31:0]) >>> b[4:0];
        case (in.op)
            OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: alu_res = add;
            OP_SUB:                             alu_res = sub;
            OP_AND, OP_ANDI:                    alu_res = in.src1 & b;
            OP_OR, OP_ORI:                      alu_res = in.src1 | b;
            OP_XOR, OP_XORI:                    alu_res = in.src1 ^ b;
            OP_SLL, OP_SLLI:                    alu_res = in.src1 << b[5:0];
            OP_SRL, OP_SRLI:                    alu_res = in.src1 >> b[5:0];
            OP_SRA, OP_SRAI:                    alu_res = $signed(in.src1) >>> b[5:0];
            OP_SLT, OP_SLTI:                    alu_res = {63'b0, $signed(in.src1) < $signed(b)};
            OP_SLTU, OP_SLTIU:                  alu_res = {63'b0, in.src1 < b};
            OP_ADDW, OP_ADDIW:                  alu_res = sext32(add[31:0]);
            OP_SUBW:                            alu_res = sext32(sub[31:0]);
            OP_SLLW, OP_SLLIW:                  alu_res = sext32(sll32);
            OP_SRLW, OP_SRLIW:                  alu_res = sext32(srl32);
            OP_SRAW, OP_SRAIW:                  alu_res = sext32(sra32);
            OP_LUI:                             alu_res = in.imm;
            OP_AUIPC:                           alu_res = in.inst_pc + in.imm;
            default:                            alu_res = '0;
        endcase
    end

    logic         is_m, w, is_div, quot_op, sa, sb, a_neg, b_neg, b_zero, ovf, ge;
    word_t        ma, mb, a_w, spec_d, diff;
    logic [64:0]  tmp, sum;
    logic [127:0] mul_d, div_d;

    // Operand preparation for an incoming M op and one iteration of each engine
    always_comb begin
        is_m = in.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM,
                             OP_REMU, OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        w = in.op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        is_div = in.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        quot_op = in.op inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW};
        sa = in.op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        sb = in.op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        a_neg = sa && (w ? in.src1[31] : in.src1[63]);
        b_neg = sb && (w ? in.src2[31] : in.src2[63]);
        ma = w ? {32'b0, a_neg ? -in.src1[31:0] : in.src1[31:0]} : (a_neg ? -in.src1 : in.src1);
        mb = w ? {32'b0, b_neg ? -in.src2[31:0] : in.src2[31:0]} : (b_neg ? -in.src2 : in.src2);
        b_zero = w ? in.src2[31:0] == 32'b0 : in.src2 == '0;
        ovf = sa && sb && is_div && (w ? in.src1[31:0] == 32'h8000_0000 && in.src2[31:0] == '1
                                       : in.src1 == {1'b1, 63'b0} && in.src2 == '1);
        a_w = w ? sext32(in.src1[31:0]) : in.src1;
        spec_d = quot_op ? (b_zero ? '1 : a_w) : (b_zero ? a_w : '0);
        tmp = {acc_q[127:64], acc_q[63]};
        ge = tmp >= {1'b0, opb_q};
        diff = tmp[63:0] - opb_q;
        div_d = {ge ? diff : tmp[63:0], acc_q[62:0], ge};
        sum = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opb_q} : 65'd0);
        mul_d = {sum, acc_q[63:1]};
    end

    word_t quo_s, rem_s, prod_hi, m_res;

    // Sign correction and result selection once the engine has finished
    always_comb begin
        quo_s = negq_q ? -acc_q[63:0] : acc_q[63:0];
        rem_s = negr_q ? -acc_q[127:64] : acc_q[127:64];
        prod_hi = negq_q ? ~acc_q[127:64] + {63'b0, acc_q[63:0] == '0} : acc_q[127:64];
        case (op_q)
            OP_MUL:                         m_res = acc_q[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   m_res = prod_hi;
            OP_MULW:                        m_res = sext32(acc_q[63:32]);
            OP_DIV, OP_DIVU:                m_res = quo_s;
            OP_REM, OP_REMU:                m_res = rem_s;
            OP_DIVW, OP_DIVUW:              m_res = sext32(quo_s[31:0]);
            OP_REMW, OP_REMUW:              m_res = sext32(rem_s[31:0]);
            default:                        m_res = '0;
        endcase
        if (special_q) m_res = spec_q;
    end

    // M-unit FSM: latch magnitudes, iterate shift-add or restoring divide, hold result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            spec_q    <= '0;
            special_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in.valid && is_m && !bus.flush) begin
                    op_q      <= in.op;
                    negq_q    <= a_neg ^ b_neg;
                    negr_q    <= a_neg;
                    spec_q    <= spec_d;
                    special_q <= is_div && (b_zero || ovf);
                    cnt_q     <= w ? 7'd32 : 7'd64;
                    acc_q     <= is_div ? {64'b0, w ? {ma[31:0], 32'b0} : ma} : {64'b0, mb};
                    opb_q     <= is_div ? mb : ma;
                    state_q   <= is_div && (b_zero || ovf) ? DONE : is_div ? DIV : MUL;
                end
                MUL, DIV: if (bus.flush) begin
                    state_q <= IDLE;
                end else begin
                    acc_q <= state_q == MUL ? mul_d : div_d;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1) state_q <= DONE;
                end
                DONE: if (bus.flush || !bus.hold) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic ok;
    assign ok = rst || state_q == DONE || (state_q == IDLE && !(in.valid && is_m));
    assign bus.ok = ok;
    assign bus.ex_mem_state = '{valid: in.valid && ok && !rst, inst: in.inst, inst_pc: in.inst_pc,
                                op: in.op, alu_result: state_q == DONE ? m_res : alu_res,
                                write_mem_data: in.src2};
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed scoreboard bench for the execute stage
module tb_execute;
    import common::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    execute_if bus();
    execute dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    int errs = 0;
    int checks = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        word_t res;
        int    rdy;
        string name;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string n, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitor: before the ready cycle ok must be low; from it on the result must be presented
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (cyc < sb[0].rdy) begin
                chk({sb[0].name, "_ok_low"}, {63'b0, bus.ok}, 64'd0);
            end else begin
                chk({sb[0].name, "_present"}, {63'b0, bus.ok & bus.ex_mem_state.valid}, 64'd1);
                chk({sb[0].name, "_result"}, bus.ex_mem_state.alu_result, sb[0].res);
                if (bus.ok && bus.ex_mem_state.valid && !bus.hold) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t op, input word_t a, input word_t b, input word_t im);
        bus.id_ex_state.valid   = 1'b1;
        bus.id_ex_state.inst    = 32'h0000_0013;
        bus.id_ex_state.inst_pc = 64'h1000;
        bus.id_ex_state.op      = op;
        bus.id_ex_state.src1    = a;
        bus.id_ex_state.src2    = b;
        bus.id_ex_state.imm     = im;
    endtask

    task automatic issue(input string n, input op_t op, input word_t a, input word_t b,
                         input word_t im, input word_t exp, input int lat, input int nh);
        exp_t e;
        int t;
        drive(op, a, b, im);
        bus.hold = nh > 0;
        e.res = exp;
        e.rdy = cyc + lat;
        e.name = n;
        sb.push_back(e);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.ok && t < 300);
        if (!bus.ok) begin
            errs++;
            checks++;
            $display("FAIL %s_timeout: ok never rose, got 0 expected 1", n);
            $display("Result: errors=%0d of %0d checks", errs, checks);
            $finish;
        end
        for (int k = 1; k < nh; k++) begin
            @(negedge clk);
            chk({n, "_hold_ok"}, {63'b0, bus.ok}, 64'd1);
        end
        if (nh > 0) begin
            step();
            bus.hold = 1'b0;
            @(negedge clk);
        end
        step();
        bus.id_ex_state.valid = 1'b0;
    endtask

    localparam word_t ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        drive(OP_MUL, 64'd5, 64'd5, 64'd0);
        #2;
        chk("rst_ok", {63'b0, bus.ok}, 64'd1);
        chk("rst_valid", {63'b0, bus.ex_mem_state.valid}, 64'd0);
        step();
        step();
        rst = 1'b0;
        bus.id_ex_state.valid = 1'b0;

        step(); issue("addi", OP_ADDI, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        step(); issue("sub", OP_SUB, 64'd10, 64'd3, 64'd0, 64'd7, 0, 0);
        step(); issue("slt", OP_SLT, ALL1, 64'd1, 64'd0, 64'd1, 0, 0);
        step(); issue("addw", OP_ADDW, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 0);
        step(); issue("srai", OP_SRAI, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'hF800_0000_0000_0000, 0, 0);
        step(); issue("store", OP_STORE, 64'h1000, 64'hAB, 64'd8, 64'h1008, 0, 0);
        step(); issue("mul", OP_MUL, ALL1, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        step(); issue("mulhu", OP_MULHU, ALL1, ALL1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        step(); issue("mulh", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd0, ALL1, 65, 0);
        step(); issue("mulhsu", OP_MULHSU, ALL1, 64'd2, 64'd0, ALL1, 65, 0);
        step(); issue("mulw", OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
        step(); issue("divw", OP_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        step(); issue("remw", OP_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, ALL1, 33, 0);
        step(); issue("rem", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, ALL1, 65, 0);
        step(); issue("div0", OP_DIV, 64'd123, 64'd0, 64'd0, ALL1, 1, 0);
        step(); issue("remu0", OP_REMU, 64'd42, 64'd0, 64'd0, 64'd42, 1, 0);
        step(); issue("divovf", OP_DIV, 64'h8000_0000_0000_0000, ALL1, 64'd0, 64'h8000_0000_0000_0000, 1, 0);
        step(); issue("divu_hold", OP_DIVU, 64'd100, 64'd7, 64'd0, 64'd14, 65, 3);

        step();
        drive(OP_DIV, 64'd1000, 64'd3, 64'd0);
        repeat (10) step();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_ok", {63'b0, bus.ok}, 64'd0);
        step();
        bus.flush = 1'b0;
        issue("after_flush", OP_ADD, 64'd2, 64'd3, 64'd0, 64'd5, 0, 0);

        step();
        drive(OP_MUL, 64'd5, 64'd5, 64'd0);
        repeat (20) step();
        rst = 1'b1;
        #1;
        chk("midrst_ok", {63'b0, bus.ok}, 64'd1);
        chk("midrst_valid", {63'b0, bus.ex_mem_state.valid}, 64'd0);
        step();
        rst = 1'b0;
        issue("mul_after_rst", OP_MUL, 64'd6, 64'd7, 64'd0, 64'd42, 65, 0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
